regfile_dump: RTL and testbench

Debug-side reader for the core register file. On a `start` pulse it walks register addresses 0..NUM_REGS-1 through one spare combinational read port and streams each value out on a valid/ready interface. It sits beside the core's decode-stage read ports, and the debug/trace logic drains it. While the dump runs, `busy` is high so the core can block writeback and the dump is a consistent snapshot.

---
 rtl/regfile_dump_pkg.sv | 14 +
 rtl/regfile_dump_if.sv | 30 +++
 rtl/regfile_dump.sv | 114 +++++++++++
 tb/tb_regfile_dump.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_dump_pkg.sv
// Shared core constants and the encoding of the register-dump FSM.
// Imported by the dump interface, the dump engine and its testbench.
package regfile_dump_pkg;

    localparam int CORE_XLEN     = 32;
    localparam int CORE_NUM_REGS = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_if.sv
// Valid/ready stream carrying one register value and its index per beat.
// The dump engine is the master; the debug/trace consumer is the slave.
interface regfile_dump_if #(
    parameter int XLEN   = regfile_dump_pkg::CORE_XLEN,
    parameter int ADDR_W = $clog2(regfile_dump_pkg::CORE_NUM_REGS)
);

    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/regfile_dump.sv
// Walks register addresses 0..NUM_REGS-1 through a spare combinational read
// port and streams each value out through a single-entry output register.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int XLEN     = CORE_XLEN,
    parameter int NUM_REGS = CORE_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [XLEN-1:0]   rf_data,
    regfile_dump_if.master    dump
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_index_q, out_index_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;

    logic load;
    logic accept;
    logic at_last;

    // A beat, once presented, stays frozen until the consumer takes it.
    assign accept  = out_valid_q && dump.out_ready;
    assign load    = (state_q == RUN) && (!out_valid_q || dump.out_ready);
    assign at_last = (idx_q == LAST_IDX);

    always_comb begin
        // NOTE: every next-state signal is given its hold value first, so no
        // path through the case statement can leave one unassigned (latch).
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                idx_d = '0;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (load) begin
                    out_valid_d = 1'b1;
                    out_data_d  = rf_data;
                    out_index_d = idx_q;
                    out_last_d  = at_last;
                    // Stop on the last address instead of wrapping idx.
                    if (at_last) begin
                        state_d = DRAIN;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (accept) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample the
        // pre-edge values together, independent of statement order.
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign rf_addr        = (state_q == RUN) ? idx_q : '0;
    assign dump.out_valid = out_valid_q;
    assign dump.out_data  = out_data_q;
    assign dump.out_index = out_index_q;
    assign dump.out_last  = out_last_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: a 32-register instance for the main
// dumps and a 2-register instance for the smallest legal configuration.
module tb_regfile_dump;
    import regfile_dump_pkg::*;

    localparam int XLEN = 32;
    localparam int NR   = 32;
    localparam int AW   = 5;

    typedef struct {
        logic [AW-1:0]   idx;
        logic [XLEN-1:0] data;
        logic            last;
    } beat_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            busy;
    logic            done;
    logic [AW-1:0]   rf_addr;
    logic [XLEN-1:0] rf_data;
    logic [XLEN-1:0] regs [NR];

    logic            s_start;
    logic            s_busy;
    logic            s_done;
    logic [0:0]      s_rf_addr;
    logic [XLEN-1:0] s_rf_data;
    logic [XLEN-1:0] s_regs [2];

    regfile_dump_if #(.XLEN(XLEN), .ADDR_W(AW)) dif ();
    regfile_dump_if #(.XLEN(XLEN), .ADDR_W(1))  sif ();

    assign rf_data   = regs[rf_addr];
    assign s_rf_data = s_regs[s_rf_addr];

    regfile_dump #(.XLEN(XLEN), .NUM_REGS(NR)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .rf_addr (rf_addr),
        .rf_data (rf_data),
        .dump    (dif.master)
    );

    regfile_dump #(.XLEN(XLEN), .NUM_REGS(2)) dut_small (
        .clk     (clk),
        .reset   (reset),
        .start   (s_start),
        .busy    (s_busy),
        .done    (s_done),
        .rf_addr (s_rf_addr),
        .rf_data (s_rf_data),
        .dump    (sif.master)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    last_fire_cyc = -10;
    int    n_done = 0;
    beat_t sbq[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_dump();
        for (int i = 0; i < NR; i++) begin
            beat_t b;
            b.idx  = AW'(i);
            b.data = regs[i];
            b.last = (i == NR - 1);
            sbq.push_back(b);
        end
    endtask

    // Compare any presented beat with the scoreboard head, pop it on a
    // handshake, then advance one clock and sample #1 after the edge.
    task automatic cycle();
        if (dif.out_valid) begin
            if (sbq.size() == 0) begin
                check("beat_without_expect", 64'(dif.out_valid), 64'd0);
            end else begin
                check("out_index", 64'(dif.out_index), 64'(sbq[0].idx));
                check("out_data", 64'(dif.out_data), 64'(sbq[0].data));
                check("out_last", 64'(dif.out_last), 64'(sbq[0].last));
                if (dif.out_ready && !reset) begin
                    if (sbq[0].last) last_fire_cyc = cyc;
                    void'(sbq.pop_front());
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (done) begin
            n_done++;
            check("done_after_last", 64'(cyc), 64'(last_fire_cyc + 1));
        end
    endtask

    task automatic run_until_done(input bit rand_ready, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            if (rand_ready) dif.out_ready = 1'($urandom_range(0, 1));
            cycle();
            n++;
        end
        if (!done) check("done_timeout", 64'(done), 64'd1);
        dif.out_ready = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_valid"}, 64'(dif.out_valid), 64'd0);
        check({tag, "_last"}, 64'(dif.out_last), 64'd0);
        check({tag, "_data"}, 64'(dif.out_data), 64'd0);
        check({tag, "_index"}, 64'(dif.out_index), 64'd0);
        check({tag, "_rf_addr"}, 64'(rf_addr), 64'd0);
    endtask

    initial begin
        int d0;
        int n;

        reset         = 1'b1;
        start         = 1'b0;
        s_start       = 1'b0;
        dif.out_ready = 1'b1;
        sif.out_ready = 1'b1;
        for (int i = 0; i < NR; i++) regs[i] = 32'hA500_0000 + 32'(i);
        s_regs[0] = 32'h1234_5678;
        s_regs[1] = 32'hDEAD_BEEF;
        cycle();
        cycle();
        reset = 1'b0;
        check_all_zero("reset");

        // Basic dump with the consumer always ready: exact cycle timing.
        start = 1'b1;
        push_dump();
        cycle();
        start = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            check("basic_busy", 64'(busy), 64'(k >= 1 && k <= 33));
            check("basic_valid", 64'(dif.out_valid), 64'(k >= 2 && k <= 33));
            check("basic_done", 64'(done), 64'(k == 34));
            if (k == 1) check("basic_rf_addr_c1", 64'(rf_addr), 64'd0);
            cycle();
        end
        check("basic_sb_empty", 64'(sbq.size()), 64'd0);

        // Random backpressure with fresh register contents.
        for (int i = 0; i < NR; i++) regs[i] = $urandom;
        start = 1'b1;
        push_dump();
        cycle();
        start = 1'b0;
        run_until_done(1'b1, 1000);
        check("bp_sb_empty", 64'(sbq.size()), 64'd0);

        // Start pulses during a dump are ignored; start in the done cycle is taken.
        d0    = n_done;
        start = 1'b1;
        push_dump();
        cycle();
        start = 1'b0;
        for (int k = 1; !done && k < 100; k++) begin
            start = (k == 5 || k == 20);
            cycle();
        end
        start = 1'b0;
        check("ign_done_seen", 64'(done), 64'd1);
        check("ign_one_done", 64'(n_done - d0), 64'd1);
        check("ign_sb_empty", 64'(sbq.size()), 64'd0);
        start = 1'b1;
        push_dump();
        cycle();
        start = 1'b0;
        check("restart_busy", 64'(busy), 64'd1);
        check("restart_rf_addr", 64'(rf_addr), 64'd0);
        run_until_done(1'b0, 200);
        check("restart_sb_empty", 64'(sbq.size()), 64'd0);

        // Reset in the middle of a dump while a beat is presented.
        cycle();
        start = 1'b1;
        push_dump();
        cycle();
        start = 1'b0;
        for (int k = 1; k < 10; k++) cycle();
        check("pre_reset_valid", 64'(dif.out_valid), 64'd1);
        d0    = n_done;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_all_zero("midreset");
        sbq.delete();
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("post_reset_busy", 64'(busy), 64'd0);
        end
        check("no_done_after_abort", 64'(n_done - d0), 64'd0);
        start = 1'b1;
        push_dump();
        cycle();
        start = 1'b0;
        check("fresh_rf_addr", 64'(rf_addr), 64'd0);
        run_until_done(1'b0, 200);
        check("fresh_sb_empty", 64'(sbq.size()), 64'd0);

        // Consumer stalls on the last beat.
        start = 1'b1;
        push_dump();
        cycle();
        start = 1'b0;
        n = 0;
        while (!(dif.out_valid && dif.out_last) && n < 100) begin
            cycle();
            n++;
        end
        check("stall_reached_last", 64'(dif.out_valid && dif.out_last), 64'd1);
        dif.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("stall_busy", 64'(busy), 64'd1);
            check("stall_done", 64'(done), 64'd0);
            cycle();
        end
        check("stall_still_valid", 64'(dif.out_valid), 64'd1);
        dif.out_ready = 1'b1;
        cycle();
        check("stall_done_pulse", 64'(done), 64'd1);
        check("stall_busy_clear", 64'(busy), 64'd0);
        check("stall_valid_clear", 64'(dif.out_valid), 64'd0);
        check("stall_sb_empty", 64'(sbq.size()), 64'd0);
        cycle();

        // Two-register instance: beats in cycles 2 and 3, done in cycle 4.
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check("small_busy", 64'(s_busy), 64'(k >= 1 && k <= 3));
            check("small_valid", 64'(sif.out_valid), 64'(k == 2 || k == 3));
            check("small_done", 64'(s_done), 64'(k == 4));
            if (k == 2 || k == 3) begin
                check("small_index", 64'(sif.out_index), 64'(k - 2));
                check("small_data", 64'(sif.out_data), 64'(s_regs[k - 2]));
                check("small_last", 64'(sif.out_last), 64'(k == 3));
            end
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
